mem_port_arbiter: RTL and testbench

//   Arbitrates the instruction-fetch (IF) and data-memory (MEM stage) requesters onto one

---
 rtl/mip32_pkg.sv | 13 +
 rtl/arb_starve_cnt.sv | 29 ++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mip32_pkg.sv
// Shared types and default widths for the mip32 unified-memory arbiter.
package mip32_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants made while a fetch was waiting.
module arb_starve_cnt #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX_VAL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_max = (r_cnt == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter
  import mip32_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_if_ready;
  logic              w_d_ready;
  logic              w_if_cap;
  logic              w_d_cap;
  logic              w_starve_inc;
  logic              w_starve_clr;
  logic              w_at_max;
  logic              w_d_req;
  logic              w_ready_pulse;

  assign w_d_req       = d_rd | d_wr;
  assign w_ready_pulse = if_ready | d_ready;
  assign stall_if      = if_req & ~if_ready;
  assign stall_mem     = w_d_req & ~d_ready;

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (w_starve_inc),
    .clr    (w_starve_clr),
    .at_max (w_at_max)
  );

  // The cycle in which a ready pulses is the mandatory idle gap: the requester
  // that was just served may still show its old request, so nothing is granted.
  always_comb begin
    w_state_nxt  = r_state;
    w_mem_en     = mem_en;
    w_mem_we     = mem_we;
    w_mem_addr   = mem_addr;
    w_mem_wdata  = mem_wdata;
    w_if_ready   = 1'b0;
    w_d_ready    = 1'b0;
    w_if_cap     = 1'b0;
    w_d_cap      = 1'b0;
    w_starve_inc = 1'b0;
    w_starve_clr = 1'b0;
    case (r_state)
      IDLE: begin
        w_mem_en     = 1'b0;
        w_starve_clr = ~if_req;
        if (!w_ready_pulse) begin
          if (w_d_req && !(if_req && w_at_max)) begin
            w_state_nxt  = BUSY_D;
            w_mem_en     = 1'b1;
            w_mem_we     = d_wr;
            w_mem_addr   = d_addr;
            w_mem_wdata  = d_wdata;
            w_starve_inc = if_req;
          end else if (if_req) begin
            w_state_nxt  = BUSY_I;
            w_mem_en     = 1'b1;
            w_mem_we     = 1'b0;
            w_mem_addr   = if_addr;
            w_starve_clr = 1'b1;
          end
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          w_state_nxt = IDLE;
          w_mem_en    = 1'b0;
          w_if_ready  = 1'b1;
          w_if_cap    = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          w_state_nxt = IDLE;
          w_mem_en    = 1'b0;
          w_d_ready   = 1'b1;
          w_d_cap     = ~mem_we;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_mem_en    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      mem_en    <= w_mem_en;
      mem_we    <= w_mem_we;
      mem_addr  <= w_mem_addr;
      mem_wdata <= w_mem_wdata;
      if_ready  <= w_if_ready;
      d_ready   <= w_d_ready;
      if (w_if_cap) begin
        if_rdata <= mem_rdata;
      end
      if (w_d_cap) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// priority/starvation/reset sequences, and randomized traffic against a reference model.
module tb_mem_port_arbiter;

  localparam int SMAX = 3;
  localparam int NR   = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  // Memory environment controls, written only by the main sequence.
  bit autoAck       = 1'b1;
  int tbLat         = 1;
  int forceAckCycle = -1;
  // Owned by the memory responder.
  int cycleCnt      = 0;
  int ackCnt        = 0;

  logic [31:0] memArr [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];

  typedef struct {
    logic        we;
    logic [31:0] addr;
  } grant_t;
  grant_t grantLog[$];
  logic   monPrevEn = 1'b0;

  typedef struct {
    string       name;
    bit          isData;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          expWe;
    logic [31:0] expRdata;
  } vec_t;
  vec_t vecs[7];

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initPattern(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : initPattern(a);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initPattern(a);
  endfunction

  // Memory model: acks a command tbLat cycles after mem_en first appears.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      cycleCnt++;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (forceAckCycle == cycleCnt) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
      end else if (autoAck && mem_en) begin
        ackCnt++;
        if (ackCnt > tbLat) begin
          mem_ack = 1'b1;
          ackCnt  = 0;
          if (mem_we) memArr[mem_addr] = mem_wdata;
          else        mem_rdata = memRead(mem_addr);
        end
      end else begin
        ackCnt = 0;
      end
    end
  end

  // Grant monitor: every rise of mem_en is one grant.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_en && !monPrevEn) grantLog.push_back('{mem_we, mem_addr});
      monPrevEn = mem_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int readyCnt;
    int grantCyc;
    readyCnt = 0;
    grantCyc = 0;
    tbLat    = v.lat;
    if (v.isData) begin
      d_rd    = v.rd;
      d_wr    = v.wr;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
    for (int c = 0; c < 40 && readyCnt == 0; c++) begin
      tick();
      if (mem_en) begin
        grantCyc++;
        checkOutput({v.name, " mem_addr"}, mem_addr, v.addr);
        checkOutput({v.name, " mem_we"}, 32'(mem_we), 32'(v.expWe));
        if (v.expWe) checkOutput({v.name, " mem_wdata"}, mem_wdata, v.wdata);
      end
      if (v.isData ? d_ready : if_ready) readyCnt++;
      else checkOutput({v.name, " stall"}, 32'(v.isData ? stall_mem : stall_if), 32'd1);
    end
    checkOutput({v.name, " ready seen"}, 32'(readyCnt), 32'd1);
    checkOutput({v.name, " busy cycles"}, 32'(grantCyc), 32'(v.lat + 1));
    checkOutput({v.name, " rdata"}, v.isData ? d_rdata : if_rdata, v.expRdata);
    checkOutput({v.name, " stall at ready"}, 32'(v.isData ? stall_mem : stall_if), 32'd0);
    d_rd   = 1'b0;
    d_wr   = 1'b0;
    if_req = 1'b0;
    tick();
    checkOutput({v.name, " ready one cycle"}, 32'(v.isData ? d_ready : if_ready), 32'd0);
    checkOutput({v.name, " mem_en idle"}, 32'(mem_en), 32'd0);
  endtask

  initial begin
    int start;
    bit ifSeen;
    bit dSeen;
    int passed;
    int maxCnt;
    bit readySeen;
    bit enSeen;
    int ifIssued, dIssued, ifDoneCnt, dDoneCnt;
    bit ifPend, dPend, dIsWr, prevEnMain, prevIfReq;
    logic [31:0] ifAddrCur, dAddrCur, dWdataCur, lastDRead;
    int passCnt, maxPass;

    memArr[32'h10] = 32'h8C22_0004;
    memArr[32'h14] = 32'h00A0_0513;
    memArr[32'h40] = 32'h1122_3344;

    vecs[0] = '{"IF fetch 0x10",   1'b0, 1'b0, 1'b0, 32'h10, 32'h0,         2, 1'b0, 32'h8C22_0004};
    vecs[1] = '{"D load 0x40",     1'b1, 1'b1, 1'b0, 32'h40, 32'h0,         1, 1'b0, 32'h1122_3344};
    vecs[2] = '{"D store 0x44",    1'b1, 1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 3, 1'b1, 32'h1122_3344};
    vecs[3] = '{"D load 0x44",     1'b1, 1'b1, 1'b0, 32'h44, 32'h0,         1, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{"D rd+wr 0x48",    1'b1, 1'b1, 1'b1, 32'h48, 32'hCAFE_F00D, 5, 1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{"IF fetch 0x14",   1'b0, 1'b0, 1'b0, 32'h14, 32'h0,         1, 1'b0, 32'h00A0_0513};
    vecs[6] = '{"D load 0x48",     1'b1, 1'b1, 1'b0, 32'h48, 32'h0,         2, 1'b0, 32'hCAFE_F00D};

    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_rd    = 1'b0;
    d_wr    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    repeat (3) tick();
    checkOutput("reset mem_en", 32'(mem_en), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset if_rdata", if_rdata, 32'd0);
    checkOutput("reset d_rdata", d_rdata, 32'd0);
    checkOutput("reset if_ready", 32'(if_ready), 32'd0);
    checkOutput("reset d_ready", 32'(d_ready), 32'd0);
    reset = 1'b0;
    tick();

    // Directed single accesses from the vector table.
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Simultaneous fetch and load: data first, then fetch; fetch stalls throughout.
    start   = grantLog.size();
    tbLat   = 1;
    if_req  = 1'b1;
    if_addr = 32'h20;
    d_rd    = 1'b1;
    d_addr  = 32'h40;
    ifSeen  = 1'b0;
    dSeen   = 1'b0;
    for (int c = 0; c < 60 && !ifSeen; c++) begin
      tick();
      if (d_ready) begin
        dSeen = 1'b1;
        checkOutput("tie d_rdata", d_rdata, 32'h1122_3344);
        d_rd = 1'b0;
      end
      if (if_ready) begin
        ifSeen = 1'b1;
        checkOutput("tie if_rdata", if_rdata, initPattern(32'h20));
        if_req = 1'b0;
      end else begin
        checkOutput("tie stall_if", 32'(stall_if), 32'd1);
      end
    end
    checkOutput("tie d served", 32'(dSeen), 32'd1);
    checkOutput("tie if served", 32'(ifSeen), 32'd1);
    checkOutput("tie grant count", 32'(grantLog.size() - start), 32'd2);
    if (grantLog.size() >= start + 2) begin
      checkOutput("tie first grant", grantLog[start].addr, 32'h40);
      checkOutput("tie second grant", grantLog[start + 1].addr, 32'h20);
    end
    repeat (2) tick();

    // Starvation: both requesters held continuously.
    start   = grantLog.size();
    maxCnt  = 0;
    tbLat   = 1;
    if_req  = 1'b1;
    if_addr = 32'h30;
    d_rd    = 1'b1;
    d_addr  = 32'h50;
    for (int c = 0; c < 200 && grantLog.size() < start + 8; c++) begin
      tick();
      if (int'(dut.u_starve.r_cnt) > maxCnt) maxCnt = int'(dut.u_starve.r_cnt);
    end
    if_req = 1'b0;
    d_rd   = 1'b0;
    checkOutput("starve grant count", 32'(grantLog.size() >= start + 8), 32'd1);
    checkOutput("starve counter peak", 32'(maxCnt), 32'(SMAX));
    passed = 0;
    for (int k = 0; k < 8 && start + k < grantLog.size(); k++) begin
      if (passed == SMAX) begin
        checkOutput($sformatf("starve grant %0d", k), grantLog[start + k].addr, 32'h30);
        passed = 0;
      end else begin
        checkOutput($sformatf("starve grant %0d", k), grantLog[start + k].addr, 32'h50);
        passed++;
      end
    end
    repeat (10) tick();

    // Reset in the middle of a data access, followed by a stray ack.
    autoAck = 1'b0;
    d_rd    = 1'b1;
    d_addr  = 32'h60;
    tick();
    tick();
    checkOutput("rst mem_en before", 32'(mem_en), 32'd1);
    forceAckCycle = cycleCnt + 4;
    reset = 1'b1;
    #1;
    checkOutput("rst mem_en async", 32'(mem_en), 32'd0);
    d_rd = 1'b0;
    tick();
    tick();
    reset     = 1'b0;
    readySeen = 1'b0;
    enSeen    = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (d_ready || if_ready) readySeen = 1'b1;
      if (mem_en) enSeen = 1'b1;
    end
    checkOutput("rst no ready", 32'(readySeen), 32'd0);
    checkOutput("rst no grant", 32'(enSeen), 32'd0);
    checkOutput("rst d_rdata", d_rdata, 32'd0);
    checkOutput("rst if_rdata", if_rdata, 32'd0);
    checkOutput("rst mem_addr", mem_addr, 32'd0);
    checkOutput("rst mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst stall_mem", 32'(stall_mem), 32'd0);
    autoAck       = 1'b1;
    forceAckCycle = -1;

    // Randomized traffic against the reference model.
    ifIssued = 0; dIssued = 0; ifDoneCnt = 0; dDoneCnt = 0;
    ifPend = 1'b0; dPend = 1'b0; dIsWr = 1'b0;
    prevEnMain = 1'b0;
    ifAddrCur = '0; dAddrCur = '0; dWdataCur = '0;
    lastDRead = 32'd0;
    passCnt = 0; maxPass = 0;
    for (int cyc = 0; cyc < 6000 && (ifDoneCnt < NR || dDoneCnt < NR); cyc++) begin
      prevIfReq = if_req;
      tick();
      checkOutput("rnd stall_if", 32'(stall_if), 32'(if_req && !if_ready));
      checkOutput("rnd stall_mem", 32'(stall_mem), 32'((d_rd || d_wr) && !d_ready));
      if (mem_en && !prevEnMain) begin
        if (mem_addr >= 32'h200) begin
          checkOutput("rnd IF grant pending", 32'(ifPend), 32'd1);
          checkOutput("rnd IF grant addr", mem_addr, ifAddrCur);
          checkOutput("rnd IF grant we", 32'(mem_we), 32'd0);
          passCnt = 0;
        end else begin
          checkOutput("rnd D grant pending", 32'(dPend), 32'd1);
          checkOutput("rnd D grant addr", mem_addr, dAddrCur);
          checkOutput("rnd D grant we", 32'(mem_we), 32'(dIsWr));
          if (dIsWr) checkOutput("rnd D grant wdata", mem_wdata, dWdataCur);
          if (prevIfReq) passCnt++;
          if (passCnt > maxPass) maxPass = passCnt;
        end
      end
      prevEnMain = mem_en;
      if (if_ready) begin
        checkOutput("rnd IF ready pending", 32'(ifPend), 32'd1);
        checkOutput("rnd if_rdata", if_rdata, initPattern(ifAddrCur));
        ifPend = 1'b0;
        if_req = 1'b0;
        ifDoneCnt++;
      end
      if (d_ready) begin
        checkOutput("rnd D ready pending", 32'(dPend), 32'd1);
        if (dIsWr) begin
          checkOutput("rnd d_rdata kept", d_rdata, lastDRead);
          refMem[dAddrCur] = dWdataCur;
        end else begin
          lastDRead = refRead(dAddrCur);
          checkOutput("rnd d_rdata", d_rdata, lastDRead);
        end
        dPend = 1'b0;
        d_rd  = 1'b0;
        d_wr  = 1'b0;
        dDoneCnt++;
      end
      if (!ifPend && ifIssued < NR && $urandom_range(0, 3) == 0) begin
        ifAddrCur = 32'h200 + 32'(4 * $urandom_range(0, 63));
        if_addr   = ifAddrCur;
        if_req    = 1'b1;
        ifPend    = 1'b1;
        passCnt   = 0;
        ifIssued++;
        tbLat     = $urandom_range(1, 4);
      end
      if (!dPend && dIssued < NR && $urandom_range(0, 2) == 0) begin
        dAddrCur  = 32'h100 + 32'(4 * $urandom_range(0, 15));
        dIsWr     = ($urandom_range(0, 1) == 1);
        dWdataCur = $urandom;
        d_addr    = dAddrCur;
        d_wdata   = dWdataCur;
        d_wr      = dIsWr;
        d_rd      = dIsWr ? ($urandom_range(0, 3) == 0) : 1'b1;
        dPend     = 1'b1;
        dIssued++;
        tbLat     = $urandom_range(1, 4);
      end
    end
    checkOutput("rnd IF completions", 32'(ifDoneCnt), 32'(NR));
    checkOutput("rnd D completions", 32'(dDoneCnt), 32'(NR));
    checkOutput("rnd starvation bound", 32'(maxPass <= SMAX), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
